// File: rtl/lvds_align_multi_pkg.sv
// Shared lane-state encoding, default comma patterns and counter sizing
// for the multi-lane LVDS word aligner.
package lvds_align_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4
  } lane_state_e;

  localparam logic [9:0] DEF_COMMA_P = 10'b01_0111_1100;
  localparam logic [9:0] DEF_COMMA_N = 10'b10_1000_0011;

  // Bits needed to hold the values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 32'sd2) ? 32'sd1 : $clog2(max_val + 32'sd1);
  endfunction

endpackage

// File: rtl/lvds_align_ch.sv
// Single-lane hunt engine: settle after start/slip, look for MATCH_CNT
// consecutive commas, otherwise request one bitslip and try again.
module lvds_align_ch
  import lvds_align_multi_pkg::*;
#(
  parameter int                DATA_W     = 10,
  parameter logic [DATA_W-1:0] COMMA_P    = DATA_W'(DEF_COMMA_P),
  parameter logic [DATA_W-1:0] COMMA_N    = DATA_W'(DEF_COMMA_N),
  parameter int                SETTLE_CYC = 10,
  parameter int                MATCH_CNT  = 3,
  parameter int                MAX_SLIP   = DATA_W,
  localparam int               SW         = cnt_w(MAX_SLIP)
) (
  input  logic              rx_clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_realign,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bitslip,
  output logic              o_align_done,
  output logic              o_align_err,
  output logic [SW-1:0]     o_slip_cnt
);

  localparam int STW = cnt_w(SETTLE_CYC);
  localparam int MW  = cnt_w(MATCH_CNT);

  lane_state_e    r_state, w_state_nxt;
  logic [STW-1:0] r_settle_cnt, w_settle_nxt;
  logic [MW-1:0]  r_match_cnt, w_match_nxt;
  logic [SW-1:0]  r_slip_cnt, w_slip_nxt;
  logic           r_bitslip, r_align_done, r_align_err, w_err_nxt;
  logic           w_match;

  assign w_match = (i_data == COMMA_P) || (i_data == COMMA_N);

  // Next-state and counter updates; enable loss and realign override the hunt.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_match_nxt  = r_match_cnt;
    w_slip_nxt   = r_slip_cnt;
    w_err_nxt    = r_align_err;
    if (!i_enable || i_realign) begin
      w_state_nxt  = ST_IDLE;
      w_settle_nxt = '0;
      w_match_nxt  = '0;
      w_slip_nxt   = '0;
      w_err_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = '0;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == STW'(SETTLE_CYC - 1)) begin
            w_state_nxt = ST_CHECK;
            w_match_nxt = '0;
          end else begin
            w_settle_nxt = r_settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            if (r_match_cnt == MW'(MATCH_CNT - 1)) begin
              w_state_nxt = ST_LOCKED;
            end else begin
              w_match_nxt = r_match_cnt + 1'b1;
            end
          end else begin
            w_state_nxt = ST_SLIP;
            w_match_nxt = '0;
            // Hitting the slip limit flags the lane but keeps hunting.
            if (r_slip_cnt == SW'(MAX_SLIP - 1)) begin
              w_slip_nxt = '0;
              w_err_nxt  = 1'b1;
            end else begin
              w_slip_nxt = r_slip_cnt + 1'b1;
            end
          end
        end
        ST_SLIP: begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = '0;
        end
        ST_LOCKED: begin
          w_state_nxt = ST_LOCKED;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered lane outputs.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_slip_cnt   <= '0;
      r_align_err  <= 1'b0;
      r_bitslip    <= 1'b0;
      r_align_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_match_cnt  <= w_match_nxt;
      r_slip_cnt   <= w_slip_nxt;
      r_align_err  <= w_err_nxt;
      r_bitslip    <= (w_state_nxt == ST_SLIP);
      r_align_done <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign o_bitslip    = r_bitslip;
  assign o_align_done = r_align_done;
  assign o_align_err  = r_align_err;
  assign o_slip_cnt   = r_slip_cnt;

endmodule

// File: rtl/lvds_align_multi.sv
// Multi-lane LVDS word aligner: one independent hunt engine per lane plus a
// registered all-lanes-locked summary.
module lvds_align_multi
  import lvds_align_multi_pkg::*;
#(
  parameter int                CH_NUM     = 4,
  parameter int                DATA_W     = 10,
  parameter logic [DATA_W-1:0] COMMA_P    = DATA_W'(DEF_COMMA_P),
  parameter logic [DATA_W-1:0] COMMA_N    = DATA_W'(DEF_COMMA_N),
  parameter int                SETTLE_CYC = 10,
  parameter int                MATCH_CNT  = 3,
  parameter int                MAX_SLIP   = DATA_W,
  localparam int               SW         = cnt_w(MAX_SLIP)
) (
  input  logic                     rx_clk,
  input  logic                     rst_n,
  input  logic                     data_cnt_done,
  input  logic                     realign,
  input  logic [CH_NUM*DATA_W-1:0] rx_data,
  output logic [CH_NUM-1:0]        bitslip,
  output logic [CH_NUM-1:0]        align_done,
  output logic                     all_align_done,
  output logic [CH_NUM-1:0]        align_err,
  output logic [CH_NUM*SW-1:0]     slip_cnt
);

  logic [CH_NUM-1:0] w_align_done;
  logic              r_all_align_done;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
    lvds_align_ch #(
      .DATA_W     (DATA_W),
      .COMMA_P    (COMMA_P),
      .COMMA_N    (COMMA_N),
      .SETTLE_CYC (SETTLE_CYC),
      .MATCH_CNT  (MATCH_CNT),
      .MAX_SLIP   (MAX_SLIP)
    ) u_ch (
      .rx_clk       (rx_clk),
      .rst_n        (rst_n),
      .i_enable     (data_cnt_done),
      .i_realign    (realign),
      .i_data       (rx_data[g*DATA_W +: DATA_W]),
      .o_bitslip    (bitslip[g]),
      .o_align_done (w_align_done[g]),
      .o_align_err  (align_err[g]),
      .o_slip_cnt   (slip_cnt[g*SW +: SW])
    );
  end

  // Summary lags lane locks by a cycle but drops together with them.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_align_done <= 1'b0;
    end else if (!data_cnt_done || realign) begin
      r_all_align_done <= 1'b0;
    end else begin
      r_all_align_done <= &w_align_done;
    end
  end

  assign align_done     = w_align_done;
  assign all_align_done = r_all_align_done;

endmodule

// File: tb/tb_lvds_align_multi.sv
// Randomised scoreboard bench for lvds_align_multi with a rotating-SERDES lane model.
module tb_lvds_align_multi;

  localparam int CH = 4, DW = 10, SC = 10, MC = 3, MS = 10, SW = 4;
  localparam logic [DW-1:0] CP = 10'b01_0111_1100;
  localparam logic [DW-1:0] CN = 10'b10_1000_0011;

  logic              rx_clk = 1'b0;
  logic              rst_n, data_cnt_done, realign;
  logic [CH*DW-1:0]  rx_data;
  logic [CH-1:0]     bitslip, align_done, align_err;
  logic              all_align_done;
  logic [CH*SW-1:0]  slip_cnt;

  lvds_align_multi dut (
    .rx_clk(rx_clk), .rst_n(rst_n), .data_cnt_done(data_cnt_done), .realign(realign),
    .rx_data(rx_data), .bitslip(bitslip), .align_done(align_done),
    .all_align_done(all_align_done), .align_err(align_err), .slip_cnt(slip_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  typedef struct {int ln; int cyc; int sc;} ev_t;
  ev_t lock_q[$];
  ev_t err_q[$];
  int  all_q[$];

  // Lane stimulus configuration
  int        off[CH];
  bit        dead[CH];
  bit        norot[CH];
  int        base[CH];
  int        tot[CH];
  int        g_lane = -1, g_rel = 0, g_edge = -1;
  bit [31:0] seed = 32'h0;

  int seen[CH] = '{default: 0};
  int bs_hi[CH] = '{default: 0};
  int bs_rise[CH] = '{default: 0};

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Word the SERDES shows at sample edge e after ns slips of this trial
  function automatic logic [DW-1:0] word(input int ln, input int e, input int ns);
    logic [2*DW-1:0] t;
    logic [DW-1:0]   b;
    int              sh;
    if (ln == g_lane && e == g_edge) return 10'h3FF;
    if (dead[ln]) return 10'h000;
    b  = seed[(e + ln) % 32] ? CN : CP;
    sh = norot[ln] ? 0 : (((off[ln] - ns) % DW) + DW) % DW;
    t  = {b, b} << sh;
    return t[2*DW-1:DW];
  endfunction

  // SERDES: each bitslip seen by the receiver rotates the lane by one bit
  always @(posedge rx_clk)
    for (int i = 0; i < CH; i++) if (bitslip[i]) seen[i] <= seen[i] + 1;

  initial begin
    rx_data = '0;
    forever begin
      @(negedge rx_clk);
      for (int i = 0; i < CH; i++) rx_data[i*DW +: DW] = word(i, cyc + 1, seen[i] - base[i]);
    end
  end

  // Reference model: walk one hunt as a sequence of attempts, queue its events
  task automatic predict(input int ln, input int t0, input int stop, output int lk);
    int s, m, hs;
    bit done;
    s = t0 + SC + 1; hs = 0; lk = -1; done = 0;
    while (!done && s < stop) begin
      m = -1;
      for (int j = 0; j < MC; j++)
        if (m < 0 && word(ln, s + j, tot[ln]) != CP && word(ln, s + j, tot[ln]) != CN) m = s + j;
      if (m < 0) begin
        if (s + MC - 1 < stop) begin
          lk = s + MC - 1;
          lock_q.push_back('{ln, lk, hs});
        end
        done = 1;
      end else if (m >= stop) begin
        done = 1;
      end else begin
        tot[ln]++;
        hs++;
        if (hs == MS) begin
          hs = 0;
          err_q.push_back('{ln, m, 0});
        end
        s = m + SC + 2;
      end
    end
  endtask

  task automatic take(input bit is_err, input int ln);
    int idx = -1;
    ev_t e;
    if (is_err) begin
      for (int k = 0; k < err_q.size(); k++) if (idx < 0 && err_q[k].ln == ln) idx = k;
    end else begin
      for (int k = 0; k < lock_q.size(); k++) if (idx < 0 && lock_q[k].ln == ln) idx = k;
    end
    if (idx < 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s lane %0d @cyc %0d: got rising edge expected none",
               is_err ? "unexpected_err" : "unexpected_lock", ln, cyc);
    end else begin
      if (is_err) begin e = err_q[idx]; err_q.delete(idx); end
      else begin e = lock_q[idx]; lock_q.delete(idx); end
      check(is_err ? "err_cycle" : "lock_cycle", cyc, e.cyc);
      check(is_err ? "err_slip_cnt" : "lock_slip_cnt", int'(slip_cnt[ln*SW +: SW]), e.sc);
    end
  endtask

  // Monitor: pop and compare whenever an output edge appears
  initial begin
    logic [CH-1:0] p_ad, p_ae, p_bs;
    logic          p_all;
    p_ad = '0; p_ae = '0; p_bs = '0; p_all = 1'b0;
    forever begin
      @(negedge rx_clk);
      if (rst_n) begin
        for (int i = 0; i < CH; i++) begin
          if (align_done[i] && !p_ad[i]) take(1'b0, i);
          if (align_err[i] && !p_ae[i]) take(1'b1, i);
          if (bitslip[i]) begin
            bs_hi[i]++;
            if (!p_bs[i]) bs_rise[i]++;
          end
        end
        if (all_align_done && !p_all) begin
          if (all_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_all_done @cyc %0d: got 1 expected 0", cyc);
          end else begin
            check("all_done_cycle", cyc, all_q.pop_front());
          end
        end
      end
      p_ad = align_done; p_ae = align_err; p_bs = bitslip; p_all = all_align_done;
    end
  end

  // One enable-high window; entered on a negedge after enable was sampled low
  task automatic run_trial(input bit do_realign);
    int t0, t1, r_edge, h_edge, maxl, nl, lk;
    int r0[CH], h0[CH];
    check("idle_zero", int'({bitslip, align_done, align_err, slip_cnt, all_align_done}), 0);
    seed = $urandom;
    for (int i = 0; i < CH; i++) begin
      base[i] = seen[i]; tot[i] = 0; r0[i] = bs_rise[i]; h0[i] = bs_hi[i];
    end
    data_cnt_done = 1'b1;
    t0 = cyc + 1;
    r_edge = t0 + SC + MC;
    t1 = do_realign ? r_edge + 1 : t0;
    g_edge = (g_lane >= 0) ? t1 + SC + 1 + g_rel : -1;
    if (do_realign) for (int i = 0; i < CH; i++) predict(i, t0, r_edge, lk);
    h_edge = t1 + 140;
    maxl = 0; nl = 0;
    for (int i = 0; i < CH; i++) begin
      predict(i, t1, h_edge + 1, lk);
      if (lk >= 0) begin nl++; if (lk > maxl) maxl = lk; end
    end
    if (nl == CH && maxl + 1 <= h_edge) all_q.push_back(maxl + 1);
    if (do_realign) begin
      while (cyc < r_edge - 1) @(negedge rx_clk);
      realign = 1'b1;
      @(negedge rx_clk);
      realign = 1'b0;
      check("realign_clear", int'({bitslip, align_done, align_err, slip_cnt, all_align_done}), 0);
    end
    while (cyc < h_edge) @(negedge rx_clk);
    data_cnt_done = 1'b0;
    @(negedge rx_clk);
    for (int i = 0; i < CH; i++) begin
      check("bitslip_pulses", bs_rise[i] - r0[i], tot[i]);
      check("bitslip_high_cycles", bs_hi[i] - h0[i], tot[i]);
    end
    check("pending_events", lock_q.size() + err_q.size() + all_q.size(), 0);
    lock_q.delete(); err_q.delete(); all_q.delete();
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < CH; i++) begin off[i] = 0; dead[i] = 0; norot[i] = 0; end
    g_lane = -1; g_rel = 0;
  endtask

  initial begin
    rst_n = 1'b0; data_cnt_done = 1'b0; realign = 1'b0;
    for (int i = 0; i < CH; i++) base[i] = 0;
    clear_cfg();
    repeat (3) @(negedge rx_clk);
    check("reset_zero", int'({bitslip, align_done, align_err, slip_cnt, all_align_done}), 0);
    rst_n = 1'b1;
    @(negedge rx_clk);

    clear_cfg();                                   run_trial(1'b0); // clean lock
    clear_cfg(); off[2] = 3;                       run_trial(1'b0); // lane offset
    clear_cfg(); dead[0] = 1;                      run_trial(1'b0); // no comma
    clear_cfg(); norot[1] = 1; g_lane = 1; g_rel = 2; run_trial(1'b0); // broken run
    clear_cfg();                                   run_trial(1'b1); // realign vs lock
    for (int t = 0; t < 7; t++) begin
      clear_cfg();
      for (int i = 0; i < CH; i++) off[i] = $urandom_range(0, DW - 1);
      if ($urandom_range(0, 2) == 0) dead[$urandom_range(0, CH - 1)] = 1;
      if ($urandom_range(0, 2) == 0) begin
        g_lane = $urandom_range(0, CH - 1);
        g_rel  = $urandom_range(0, MC - 1);
      end
      run_trial($urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
